// File: rtl/maindec_ext.sv
// Multi-cycle MIPS main control FSM with memory wait/timeout handling and a trap state.
// Outputs are decoded combinationally from the current state, the opcode and mem_ready.
module maindec_ext #(
    parameter int MEM_WAIT_EN = 1,
    parameter int TIMEOUT     = 16,
    parameter int ENABLE_EXT  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       pcwrite,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       branch,
    output logic       bne,
    output logic       iord,
    output logic       immext,
    output logic [1:0] regdst,
    output logic [1:0] wdsel,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] aluop,
    output logic [3:0] state_o,
    output logic [1:0] trap_cause
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BREX    = 4'd8,
        IMMEX   = 4'd9,
        IMMWB   = 4'd10,
        JEX     = 4'd11,
        JALEX   = 4'd12,
        TRAP    = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic       EXT_OK  = (ENABLE_EXT != 0);
    localparam logic       WAIT_OK = (MEM_WAIT_EN != 0);
    localparam logic       TO_EN   = WAIT_OK && (TIMEOUT != 0);
    localparam logic [7:0] TO_LAST = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t     state_reg, state_next;
    logic [7:0] wait_cnt_reg, wait_cnt_next;
    logic [1:0] trap_cause_reg, trap_cause_next;
    logic       rdy;
    logic       mem_state;
    logic       timeout;
    logic       entering;

    assign rdy       = WAIT_OK ? mem_ready : 1'b1;
    assign mem_state = (state_reg == FETCH) || (state_reg == MEMRD) || (state_reg == MEMWR);
    // A ready on the last allowed cycle wins over the timeout.
    assign timeout   = TO_EN && mem_state && !mem_ready && (wait_cnt_reg == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= FETCH;
            wait_cnt_reg   <= 8'd0;
            trap_cause_reg <= 2'b00;
        end else begin
            state_reg      <= state_next;
            wait_cnt_reg   <= wait_cnt_next;
            trap_cause_reg <= trap_cause_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        trap_cause_next = trap_cause_reg;
        case (state_reg)
            FETCH: begin
                if (timeout) begin
                    state_next      = TRAP;
                    trap_cause_next = 2'b10;
                end else if (rdy) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                case (op)
                    OP_LW, OP_SW:              state_next = MEMADR;
                    OP_RTYPE:                  state_next = RTYPEEX;
                    OP_BEQ:                    state_next = BREX;
                    OP_ADDI:                   state_next = IMMEX;
                    OP_J:                      state_next = JEX;
                    OP_BNE:                    state_next = EXT_OK ? BREX : TRAP;
                    OP_ANDI, OP_ORI, OP_SLTI:  state_next = EXT_OK ? IMMEX : TRAP;
                    OP_JAL:                    state_next = EXT_OK ? JALEX : TRAP;
                    default:                   state_next = TRAP;
                endcase
                if (state_next == TRAP)
                    trap_cause_next = 2'b01;
            end
            MEMADR:  state_next = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD, MEMWR: begin
                if (timeout) begin
                    state_next      = TRAP;
                    trap_cause_next = 2'b10;
                end else if (rdy) begin
                    state_next = (state_reg == MEMRD) ? MEMWB : FETCH;
                end
            end
            RTYPEEX: state_next = RTYPEWB;
            IMMEX:   state_next = IMMWB;
            TRAP:    state_next = TRAP;
            default: state_next = FETCH;
        endcase
    end

    assign entering = (state_next != state_reg) &&
                      ((state_next == FETCH) || (state_next == MEMRD) || (state_next == MEMWR));

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (entering || rdy || timeout)
            wait_cnt_next = 8'd0;
        else if (mem_req)
            wait_cnt_next = wait_cnt_reg + 8'd1;
    end

    always_comb begin
        mem_req  = 1'b0;
        pcwrite  = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        branch   = 1'b0;
        bne      = 1'b0;
        iord     = 1'b0;
        immext   = 1'b0;
        regdst   = 2'b00;
        wdsel    = 2'b00;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 3'b000;
        case (state_reg)
            FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                pcwrite = rdy;
                irwrite = rdy;
            end
            DECODE:  alusrcb = 2'b11;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            MEMWB: begin
                regwrite = 1'b1;
                wdsel    = 2'b01;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = !timeout;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 3'b010;
            end
            RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 2'b01;
            end
            BREX: begin
                alusrca = 1'b1;
                aluop   = 3'b001;
                pcsrc   = 2'b01;
                branch  = (op == OP_BEQ);
                bne     = (op == OP_BNE);
            end
            IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                case (op)
                    OP_ANDI: aluop = 3'b011;
                    OP_ORI:  aluop = 3'b100;
                    OP_SLTI: aluop = 3'b101;
                    default: aluop = 3'b000;
                endcase
                immext = (op == OP_ANDI) || (op == OP_ORI);
            end
            IMMWB:   regwrite = 1'b1;
            JEX: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b10;
            end
            JALEX: begin
                pcwrite  = 1'b1;
                pcsrc    = 2'b10;
                regwrite = 1'b1;
                regdst   = 2'b10;
                wdsel    = 2'b10;
            end
            default: ;
        endcase
    end

    assign state_o    = state_reg;
    assign trap_cause = trap_cause_reg;

endmodule

// File: tb/tb_maindec_ext.sv
// Directed bench for maindec_ext: three instances (default, no extensions, TIMEOUT=4)
// share one stimulus stream; each scenario checks the instance it targets.
module tb_maindec_ext;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_RTYP = 6'b000000;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;

    logic [2:0] mem_req_a, pcwrite_a, memwrite_a, irwrite_a, regwrite_a;
    logic [2:0] alusrca_a, branch_a, bne_a, iord_a, immext_a;
    logic [1:0] regdst_a [3];
    logic [1:0] wdsel_a [3];
    logic [1:0] alusrcb_a [3];
    logic [1:0] pcsrc_a [3];
    logic [2:0] aluop_a [3];
    logic [3:0] state_a [3];
    logic [1:0] cause_a [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Instance 0: defaults; 1: ENABLE_EXT=0; 2: TIMEOUT=4.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            maindec_ext #(
                .MEM_WAIT_EN(1),
                .TIMEOUT    ((gi == 2) ? 4 : 16),
                .ENABLE_EXT ((gi == 1) ? 0 : 1)
            ) u_dut (
                .clk       (clk),
                .reset     (reset),
                .op        (op),
                .mem_ready (mem_ready),
                .mem_req   (mem_req_a[gi]),
                .pcwrite   (pcwrite_a[gi]),
                .memwrite  (memwrite_a[gi]),
                .irwrite   (irwrite_a[gi]),
                .regwrite  (regwrite_a[gi]),
                .alusrca   (alusrca_a[gi]),
                .branch    (branch_a[gi]),
                .bne       (bne_a[gi]),
                .iord      (iord_a[gi]),
                .immext    (immext_a[gi]),
                .regdst    (regdst_a[gi]),
                .wdsel     (wdsel_a[gi]),
                .alusrcb   (alusrcb_a[gi]),
                .pcsrc     (pcsrc_a[gi]),
                .aluop     (aluop_a[gi]),
                .state_o   (state_a[gi]),
                .trap_cause(cause_a[gi])
            );
        end
    endgenerate

    task automatic check_val(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, then let combinational outputs settle before sampling.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic [5:0] opcode, input logic rdy);
        reset     = 1'b1;
        op        = opcode;
        mem_ready = rdy;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        op        = OP_LW;
        mem_ready = 1'b1;

        // LW: 0,1,2,3,4,0
        do_reset(OP_LW, 1'b1);
        check_val("rst_state", state_a[0], 0);
        check_val("rst_cause", cause_a[0], 0);
        check_val("fetch_pcwrite", pcwrite_a[0], 1);
        check_val("fetch_alusrcb", alusrcb_a[0], 1);
        tick(); check_val("lw_s1", state_a[0], 1);
        check_val("decode_alusrcb", alusrcb_a[0], 3);
        tick(); check_val("lw_s2", state_a[0], 2);
        tick(); check_val("lw_s3", state_a[0], 3);
        check_val("memrd_iord", iord_a[0], 1);
        tick(); check_val("lw_s4", state_a[0], 4);
        check_val("memwb_regwrite", regwrite_a[0], 1);
        check_val("memwb_wdsel", wdsel_a[0], 1);
        tick(); check_val("lw_s0", state_a[0], 0);
        $display("txn LW done");

        // ORI with and without extensions
        do_reset(OP_ORI, 1'b1);
        tick(); check_val("ori_s1", state_a[0], 1);
        tick(); check_val("ori_s9", state_a[0], 9);
        check_val("ori_aluop", aluop_a[0], 4);
        check_val("ori_immext", immext_a[0], 1);
        check_val("noext_trap", state_a[1], 13);
        check_val("noext_cause", cause_a[1], 1);
        tick(); check_val("ori_s10", state_a[0], 10);
        check_val("trap_hold", state_a[1], 13);
        check_val("trap_mem_req", mem_req_a[1], 0);
        reset = 1'b1;
        tick(); check_val("trap_rst", state_a[1], 0);
        check_val("trap_rst_cause", cause_a[1], 0);
        reset = 1'b0;
        $display("txn ORI done");

        // JAL
        do_reset(OP_JAL, 1'b1);
        tick(); tick();
        check_val("jal_s12", state_a[0], 12);
        check_val("jal_pcwrite", pcwrite_a[0], 1);
        check_val("jal_pcsrc", pcsrc_a[0], 2);
        check_val("jal_regwrite", regwrite_a[0], 1);
        check_val("jal_regdst", regdst_a[0], 2);
        check_val("jal_wdsel", wdsel_a[0], 2);
        tick(); check_val("jal_s0", state_a[0], 0);
        $display("txn JAL done");

        // BNE and R-type
        do_reset(OP_BNE, 1'b1);
        tick(); tick();
        check_val("bne_s8", state_a[0], 8);
        check_val("bne_bne", bne_a[0], 1);
        check_val("bne_branch", branch_a[0], 0);
        check_val("bne_aluop", aluop_a[0], 1);
        check_val("bne_pcsrc", pcsrc_a[0], 1);
        do_reset(OP_RTYP, 1'b1);
        tick(); tick();
        check_val("rt_s6", state_a[0], 6);
        check_val("rt_aluop", aluop_a[0], 2);
        tick(); check_val("rt_regdst", regdst_a[0], 1);
        $display("txn BNE/RTYPE done");

        // SW with 3 stall cycles in MEMWR
        do_reset(OP_SW, 1'b1);
        tick(); tick(); tick();
        check_val("sw_s5", state_a[0], 5);
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b0;
            #1;
            check_val("sw_wait_memwrite", memwrite_a[0], 1);
            check_val("sw_wait_state", state_a[0], 5);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check_val("sw_rdy_memwrite", memwrite_a[0], 1);
        check_val("sw_rdy_state", state_a[0], 5);
        tick(); check_val("sw_s0", state_a[0], 0);
        $display("txn SW stall done");

        // FETCH stall
        do_reset(OP_LW, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_val("fstall_pcwrite", pcwrite_a[0], 0);
            check_val("fstall_irwrite", irwrite_a[0], 0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check_val("frdy_pcwrite", pcwrite_a[0], 1);
        check_val("frdy_irwrite", irwrite_a[0], 1);
        tick(); check_val("frdy_s1", state_a[0], 1);
        $display("txn FETCH stall done");

        // Timeout in FETCH (TIMEOUT=4)
        do_reset(OP_LW, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_val("to_state", state_a[2], 0);
            check_val("to_pcwrite", pcwrite_a[2], 0);
            tick();
        end
        check_val("to_trap", state_a[2], 13);
        check_val("to_cause", cause_a[2], 2);
        // Ready arriving on the 4th cycle completes instead
        do_reset(OP_LW, 1'b0);
        tick(); tick(); tick();
        mem_ready = 1'b1;
        #1;
        check_val("to_late_pcwrite", pcwrite_a[2], 1);
        tick();
        check_val("to_late_state", state_a[2], 1);
        check_val("to_late_cause", cause_a[2], 0);
        $display("txn timeout done");

        // Reset mid-wait in MEMRD; counter must restart from 0
        do_reset(OP_LW, 1'b1);
        tick(); tick(); tick();
        check_val("mrd_s3", state_a[2], 3);
        mem_ready = 1'b0;
        tick(); tick();
        check_val("mrd_wait", state_a[2], 3);
        reset = 1'b1;
        tick();
        check_val("mrd_rst_state", state_a[2], 0);
        check_val("mrd_rst_cause", cause_a[2], 0);
        reset = 1'b0;
        tick(); tick(); tick();
        check_val("mrd_cnt_fresh", state_a[2], 0);
        tick();
        check_val("mrd_cnt_trap", state_a[2], 13);
        $display("txn MEMRD reset done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
